// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for pipeline staging logic.
//   PIPE_PC_W / PIPE_DATA_W : widest PC / instruction payload an entry can carry
//   NOP_WORD_DEFAULT        : instruction presented downstream when no entry is held
//   pipe_entry_t            : one pipeline entry (pc, instr)
package pipe_pkg;

    localparam int PIPE_PC_W   = 32;
    localparam int PIPE_DATA_W = 32;

    localparam logic [PIPE_DATA_W-1:0] NOP_WORD_DEFAULT = '0;

    typedef struct packed {
        logic [PIPE_PC_W-1:0]   pc;
        logic [PIPE_DATA_W-1:0] instr;
    } pipe_entry_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- saturating up-counter with synchronous clear.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (count returns to 0)
//   inc   : add one this cycle unless already at all-ones
//   clr   : synchronous clear, wins over inc
//   cnt   : current count
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage -- two-entry valid/ready pipeline stage (head + skid register).
// The head register drives the outputs; the skid register catches the one entry
// that arrives while the head is stalled, so in_ready can be a pure register.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : upstream handshake; in_pc/in_instr payload
//   flush                : drop everything held and offered this cycle
//   out_valid/out_ready  : downstream handshake; out_pc/out_instr payload
//   cnt_clr              : synchronous clear of bp_cnt
//   bp_cnt               : saturating count of cycles stalled by downstream
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                PC_W     = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_instr,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bp_cnt
);

    logic        head_valid_q, head_valid_d;
    logic        skid_valid_q, skid_valid_d;
    pipe_entry_t head_q, head_d;
    pipe_entry_t skid_q, skid_d;
    pipe_entry_t in_entry;
    logic        accept;
    logic        xfer;

    // Payloads narrower than the package entry are zero-extended on entry.
    always_comb begin
        in_entry       = '0;
        in_entry.pc    = PIPE_PC_W'(in_pc);
        in_entry.instr = PIPE_DATA_W'(in_instr);
    end

    // A full skid register is the only reason to refuse input, so in_ready
    // depends on state alone and never on out_ready.
    assign in_ready = ~skid_valid_q;

    assign accept = in_valid & ~skid_valid_q & ~flush;
    assign xfer   = head_valid_q & out_ready & ~flush;

    always_comb begin
        head_d       = head_q;
        skid_d       = skid_q;
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Payloads are left alone so out_pc keeps showing the last head PC.
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (xfer) begin
            if (skid_valid_q) begin
                // accept is impossible here (in_ready is low), so skid just drains.
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                head_d = in_entry;
            end else begin
                head_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (head_valid_q) begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end else begin
                head_d       = in_entry;
                head_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            head_q       <= '0;
            skid_q       <= '0;
        end else begin
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
        end
    end

    // flush masks out_valid in the same cycle; this is the only input-to-output path.
    assign out_valid = head_valid_q & ~flush;
    assign out_pc    = head_q.pc[PC_W-1:0];
    assign out_instr = out_valid ? head_q.instr[DATA_W-1:0] : NOP_WORD;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~out_ready),
        .clr   (cnt_clr),
        .cnt   (bp_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
`timescale 1ns/1ps
module tb_pipe_skid_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          CNTW  = 4;
    localparam int          BPMAX = (1 << CNTW) - 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_pc;
    logic [31:0]     in_instr;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_pc;
    logic [31:0]     out_instr;
    logic            cnt_clr;
    logic [CNTW-1:0] bp_cnt;

    pipe_skid_stage #(
        .DATA_W   (32),
        .PC_W     (32),
        .NOP_WORD (NOP),
        .CNT_W    (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .cnt_clr   (cnt_clr),
        .bp_cnt    (bp_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the stage is a FIFO of capacity two.
    ent_t        held[$];
    ent_t        sb_q[$];
    logic [31:0] last_pc = '0;
    int          bp_m    = 0;

    // Expectations for the current cycle, published by the stimulus process.
    logic        exp_in_ready  = 1'b1;
    logic        exp_out_valid = 1'b0;
    logic [31:0] exp_out_pc    = '0;
    logic [31:0] exp_out_instr = NOP;
    int          exp_bp        = 0;
    logic        mon_en        = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs (called just after a rising edge), publish the
    // expected outputs, then advance the model across the next edge.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic fl, input logic ordy, input logic clr);
        logic acc;
        logic xfr;
        ent_t e;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        flush     = fl;
        out_ready = ordy;
        cnt_clr   = clr;
        e.pc      = pc;
        e.instr   = ins;

        exp_in_ready  = (held.size() < 2);
        exp_out_valid = (held.size() > 0) && !fl;
        exp_out_pc    = (held.size() > 0) ? held[0].pc : last_pc;
        exp_out_instr = exp_out_valid ? held[0].instr : NOP;
        exp_bp        = bp_m;
        acc = iv && (held.size() < 2) && !fl;
        xfr = exp_out_valid && ordy;
        if (acc) sb_q.push_back(e);

        @(posedge clk);
        if (fl) begin
            held.delete();
        end else begin
            if (xfr) void'(held.pop_front());
            if (acc) held.push_back(e);
        end
        if (held.size() > 0) last_pc = held[0].pc;
        if (clr) bp_m = 0;
        else if (exp_out_valid && !ordy && bp_m < BPMAX) bp_m = bp_m + 1;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {31'b0, in_ready},  32'd1);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_out_instr"}, out_instr,          NOP);
        chk({tag, "_out_pc"},    out_pc,             32'h0);
        chk({tag, "_bp_cnt"},    32'(bp_cnt),        32'h0);
    endtask

    // Monitor: checks the published cycle expectations and scoreboards every
    // transfer the DUT actually makes.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready",  {31'b0, in_ready},  {31'b0, exp_in_ready});
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_out_valid});
            chk("out_pc",    out_pc,             exp_out_pc);
            chk("out_instr", out_instr,          exp_out_instr);
            chk("bp_cnt",    32'(bp_cnt),        32'(exp_bp));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_spurious: got pc 0x%08h expected no transfer at %0t", out_pc, $time);
                end else begin
                    ent_t e;
                    e = sb_q.pop_front();
                    chk("sb_pc",    out_pc,    e.pc);
                    chk("sb_instr", out_instr, e.instr);
                end
            end
            if (flush) sb_q.delete();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Back-to-back stream through an empty stage.
        step(1'b1, 32'h100, 32'hA000_0000, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h104, 32'hA000_0001, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h108, 32'hA000_0002, 1'b0, 1'b1, 1'b0);
        repeat (2) idle();

        // Stall: head and skid fill, third entry waits upstream.
        step(1'b1, 32'h200, 32'hB000_0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h204, 32'hB000_0001, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 32'h208, 32'hB000_0002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h208, 32'hB000_0002, 1'b0, 1'b1, 1'b0);
        repeat (3) idle();

        // Flush with both entries held and a new entry offered.
        step(1'b1, 32'h300, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h304, 32'hC000_0001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h308, 32'hC000_0002, 1'b1, 1'b1, 1'b0);
        idle();
        step(1'b1, 32'h30C, 32'hC000_0003, 1'b0, 1'b1, 1'b0);
        idle();

        // Backpressure counter saturation and clear during a stall.
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h400, 32'hD000_0000, 1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("bp_saturated", 32'(bp_cnt), 32'(BPMAX));
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("bp_cleared", 32'(bp_cnt), 32'h0);
        repeat (2) idle();

        // Asynchronous reset with both entries full.
        step(1'b1, 32'h500, 32'hE000_0000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h504, 32'hE000_0001, 1'b0, 1'b0, 1'b0);
        mon_en    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        held.delete();
        sb_q.delete();
        last_pc = '0;
        bp_m    = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        step(1'b1, 32'h600, 32'hF000_0000, 1'b0, 1'b1, 1'b0);
        idle();

        // Randomized traffic against the FIFO model.
        repeat (10000) begin
            step(($urandom % 4) != 0, $urandom, $urandom,
                 ($urandom % 64) == 0, ($urandom % 3) != 0, ($urandom % 97) == 0);
        end
        repeat (4) idle();
        chk("sb_drained", sb_q.size(), 32'd0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
